mem_port_arbiter: RTL

Round-robin arbiter sharing the single data-cache request port (CACHE::cache_cmd_t command, 64-bit address/data, respcyc/resp_data return) among up to four requesters, e.g. the memory micro-op pipeline and instruction fetch. It sits between the requesters and the cache. It locks a grant from issue until the cache's response cycle, routes the response back to the granted requester only, and flags protocol violations and response timeouts.

---
 rtl/CACHE.sv | 8 +
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/CACHE.sv
// Shared data-cache command encoding used on both sides of the cache port.
package CACHE;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } cache_cmd_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-cache request port among NREQ requesters.
// A grant is held from issue until the cache response cycle; errors are sticky.
module mem_port_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  CACHE::cache_cmd_t         rq_cmd       [NREQ],
  input  logic [63:0]               rq_addr      [NREQ],
  input  logic [63:0]               rq_data      [NREQ],
  output logic [NREQ-1:0]           rq_respcyc,
  output logic [63:0]               rq_resp_data,
  output CACHE::cache_cmd_t         ca_req_cmd,
  output logic [63:0]               ca_req_addr,
  output logic [63:0]               ca_req_data,
  input  logic                      ca_respcyc,
  input  logic [63:0]               ca_resp_data,
  output logic                      grant_valid,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      timeout_err,
  output logic                      proto_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   grant_id_reg, grant_id_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            timeout_err_reg, timeout_err_next;
  logic            proto_err_reg, proto_err_next;

  logic [NREQ-1:0] req_vec;
  logic [NREQ-1:0] scan_req;
  logic [IW-1:0]   scan_start;
  logic [IW-1:0]   gid_inc;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   win_id;
  logic            win_found;
  logic            busy;

  assign busy    = (state_reg == S_BUSY);
  assign gid_inc = (grant_id_reg == IW'(NREQ - 1)) ? '0 : grant_id_reg + IW'(1);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_vec[gi]    = (rq_cmd[gi] != CACHE::IDLE);
      assign rq_respcyc[gi] = busy && ca_respcyc && (grant_id_reg == IW'(gi));
    end
  endgenerate

  // After a response the just-served requester is masked so its next request waits a cycle.
  always_comb begin
    scan_req   = req_vec;
    scan_start = rr_ptr_reg;
    if (busy) begin
      scan_req[grant_id_reg] = 1'b0;
      scan_start             = gid_inc;
    end
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    // Walk backwards so the closest requester to scan_start is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(scan_start) + k) % NREQ);
      if (scan_req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_id_next    = grant_id_reg;
    rr_ptr_next      = rr_ptr_reg;
    cnt_next         = cnt_reg;
    timeout_err_next = timeout_err_reg;
    proto_err_next   = proto_err_reg;
    case (state_reg)
      S_IDLE: begin
        if (ca_respcyc) begin
          proto_err_next = 1'b1;
        end
        if (win_found) begin
          state_next    = S_BUSY;
          grant_id_next = win_id;
          cnt_next      = '0;
        end
      end
      S_BUSY: begin
        if (ca_respcyc) begin
          rr_ptr_next = gid_inc;
          cnt_next    = '0;
          if (win_found) begin
            grant_id_next = win_id;
          end else begin
            state_next = S_IDLE;
          end
        end else if (!req_vec[grant_id_reg]) begin
          proto_err_next = 1'b1;
          state_next     = S_IDLE;
        end else begin
          if (cnt_reg != CW'(TIMEOUT)) begin
            cnt_next = cnt_reg + CW'(1);
          end
          if ((TIMEOUT != 0) && (cnt_next == CW'(TIMEOUT))) begin
            timeout_err_next = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      grant_id_reg    <= '0;
      rr_ptr_reg      <= '0;
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_id_reg    <= grant_id_next;
      rr_ptr_reg      <= rr_ptr_next;
      cnt_reg         <= cnt_next;
      timeout_err_reg <= timeout_err_next;
      proto_err_reg   <= proto_err_next;
    end
  end

  assign grant_valid  = busy;
  assign grant_id     = grant_id_reg;
  assign timeout_err  = timeout_err_reg;
  assign proto_err    = proto_err_reg;
  assign rq_resp_data = ca_resp_data;
  assign ca_req_cmd   = busy ? rq_cmd[grant_id_reg] : CACHE::IDLE;
  assign ca_req_addr  = rq_addr[grant_id_reg];
  assign ca_req_data  = rq_data[grant_id_reg];

endmodule
